// File: rtl/uart_pkt_parser.sv
// uart_pkt_parser
// Framed-packet decoder sitting behind the UART receiver. Hunts for
// [SOF][LEN][PAYLOAD x LEN][CHK] frames, buffers the payload, and verifies
// the XOR checksum over LEN and payload. Good packets are replayed on a
// valid/ready byte stream. Bad frames raise one-cycle error pulses.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_HUNT    | idle, dropping bytes until SOF
//   ST_LEN     | SOF seen, waiting for the LEN byte
//   ST_PAYLOAD | storing payload bytes into the buffer
//   ST_CHK     | waiting for the checksum byte
//   ST_SEND    | replaying the buffered payload to the consumer
module uart_pkt_parser #(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned BIT_RATE      = 9600,
    parameter logic [7:0]  SOF           = 8'hA5,
    parameter int unsigned MAX_LEN       = 64,
    parameter int unsigned TIMEOUT_BYTES = 4,
    parameter int unsigned TIMEOUT_CLKS  = 10 * (CLK_HZ / BIT_RATE) * TIMEOUT_BYTES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic       pkt_last,
    output logic [7:0] pkt_len,
    output logic       busy,
    output logic       frame_err,
    output logic       len_err,
    output logic       chk_err,
    output logic       timeout_err,
    output logic       overrun
);

    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_SEND
    } state_t;

    state_t             state_q, state_nxt;
    logic [7:0]         len_q, len_nxt;
    logic [7:0]         chk_q, chk_nxt;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic [IDX_W-1:0]   rd_q, rd_nxt;
    logic [31:0]        tmr_q, tmr_nxt;
    logic [7:0]         pkt_len_nxt;
    logic               frame_nxt, len_err_nxt, chk_err_nxt, timeout_nxt, overrun_nxt;
    logic               buf_we;
    logic               rx_byte;
    logic               send_last;
    logic [7:0]         buf_mem [MAX_LEN];

    // A byte that arrives together with a receiver error is not trusted.
    assign rx_byte   = rx_valid & ~rx_err;
    assign send_last = (8'(rd_q) == len_q - 8'd1);

    // Gate the stream outputs so nothing leaks from the buffer outside SEND.
    assign pkt_valid = (state_q == ST_SEND);
    assign pkt_data  = (state_q == ST_SEND) ? buf_mem[rd_q] : 8'h00;
    assign pkt_last  = (state_q == ST_SEND) & send_last;

    // State and datapath registers; reset clears everything except the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            len_q       <= 8'h00;
            chk_q       <= 8'h00;
            idx_q       <= '0;
            rd_q        <= '0;
            tmr_q       <= 32'd0;
            pkt_len     <= 8'h00;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
            len_err     <= 1'b0;
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            len_q       <= len_nxt;
            chk_q       <= chk_nxt;
            idx_q       <= idx_nxt;
            rd_q        <= rd_nxt;
            tmr_q       <= tmr_nxt;
            pkt_len     <= pkt_len_nxt;
            busy        <= (state_nxt != ST_HUNT);
            frame_err   <= frame_nxt;
            len_err     <= len_err_nxt;
            chk_err     <= chk_err_nxt;
            timeout_err <= timeout_nxt;
            overrun     <= overrun_nxt;
        end
    end

    // Payload buffer write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[idx_q] <= rx_data;
        end
    end

    // Next-state logic. The gap timer is a down-counter reloaded on each byte;
    // it expires on the TIMEOUT_CLKS-th idle cycle and beats a same-cycle byte.
    always_comb begin
        state_nxt   = state_q;
        len_nxt     = len_q;
        chk_nxt     = chk_q;
        idx_nxt     = idx_q;
        rd_nxt      = rd_q;
        tmr_nxt     = tmr_q;
        pkt_len_nxt = pkt_len;
        frame_nxt   = 1'b0;
        len_err_nxt = 1'b0;
        chk_err_nxt = 1'b0;
        timeout_nxt = 1'b0;
        overrun_nxt = 1'b0;
        buf_we      = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (rx_err) begin
                    frame_nxt = 1'b1;
                end else if (rx_byte && rx_data == SOF) begin
                    state_nxt = ST_LEN;
                    tmr_nxt   = TIMEOUT_CLKS;
                end
            end

            ST_LEN, ST_PAYLOAD, ST_CHK: begin
                if (rx_err) begin
                    frame_nxt = 1'b1;
                    state_nxt = ST_HUNT;
                end else if (tmr_q == 32'd1) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = ST_HUNT;
                end else if (rx_byte) begin
                    tmr_nxt = TIMEOUT_CLKS;
                    if (state_q == ST_LEN) begin
                        if (rx_data == 8'h00 || rx_data > 8'(MAX_LEN)) begin
                            len_err_nxt = 1'b1;
                            state_nxt   = ST_HUNT;
                        end else begin
                            len_nxt   = rx_data;
                            chk_nxt   = rx_data;
                            idx_nxt   = '0;
                            state_nxt = ST_PAYLOAD;
                        end
                    end else if (state_q == ST_PAYLOAD) begin
                        buf_we  = 1'b1;
                        chk_nxt = chk_q ^ rx_data;
                        if (8'(idx_q) == len_q - 8'd1) begin
                            state_nxt = ST_CHK;
                        end else begin
                            idx_nxt = idx_q + IDX_W'(1);
                        end
                    end else begin
                        if (rx_data == chk_q) begin
                            rd_nxt      = '0;
                            pkt_len_nxt = len_q;
                            state_nxt   = ST_SEND;
                        end else begin
                            chk_err_nxt = 1'b1;
                            state_nxt   = ST_HUNT;
                        end
                    end
                end else begin
                    tmr_nxt = tmr_q - 32'd1;
                end
            end

            ST_SEND: begin
                if (rx_valid || rx_err) begin
                    overrun_nxt = 1'b1;
                end
                if (pkt_ready) begin
                    if (send_last) begin
                        pkt_len_nxt = 8'h00;
                        state_nxt   = ST_HUNT;
                    end else begin
                        rd_nxt = rd_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = ST_HUNT;
            end
        endcase
    end

endmodule
